// File: rtl/fila.sv
// rtl/fila.sv - byte FIFO behind the deserializer, four-phase ready/ack capture, pop on dequeue_in.
// Optional FILA_DROP_OLDEST_EN: full queue overwrites its oldest byte instead of withholding ack_out.
`timescale 1ns/1ps
module fila #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk_100KHz,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       data_ready_in,
  output logic                       ack_out,
  input  logic                       dequeue_in,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       empty_out,
  output logic                       full_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FULL_LEN = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

  state_t          state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]   wr;
  logic [AW-1:0]   rd;
  logic [LW-1:0]   len;
  logic            pop;
  logic            room;
  logic            capture;
  logic            overwrite;

  assign pop = dequeue_in && (len != '0);

`ifdef FILA_DROP_OLDEST_EN
  assign room = 1'b1;
`else
  assign room = (len < FULL_LEN) || pop;
`endif

  assign capture   = (state == IDLE) && data_ready_in && room;
  // Only reachable in drop-oldest builds: the new byte lands on the oldest slot.
  assign overwrite = capture && !pop && (len == FULL_LEN);

  assign len_out   = len;
  assign empty_out = (len == '0);
  assign full_out  = (len == FULL_LEN);

  always_ff @(posedge clk_100KHz) begin
    if (capture) begin
      mem[wr] <= data_in;
    end
  end

  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ack_out  <= 1'b0;
      data_out <= '0;
      wr       <= '0;
      rd       <= '0;
      len      <= '0;
    end else begin
      if (capture) begin
        wr <= wr + 1'b1;
      end
      if (pop) begin
        data_out <= mem[rd];
      end
      if (pop || overwrite) begin
        rd <= rd + 1'b1;
      end

      if (capture && !pop && !overwrite) begin
        len <= len + 1'b1;
      end else if (pop && !capture) begin
        len <= len - 1'b1;
      end

      case (state)
        IDLE: begin
          if (capture) begin
            state   <= ACK;
            ack_out <= 1'b1;
          end else begin
            ack_out <= 1'b0;
          end
        end
        ACK: begin
          state   <= WAIT_LOW;
          ack_out <= 1'b0;
        end
        WAIT_LOW: begin
          ack_out <= 1'b0;
          // Hold here until the deserializer releases ready, so one byte is never taken twice.
          if (!data_ready_in) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          ack_out <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/fila.md
# fila

Byte FIFO stage directly downstream of the serial-to-byte deserializer. Captures each byte presented with `data_ready_in` through a four-phase ready/ack handshake, stores up to `DEPTH` bytes, and releases them one per cycle on `dequeue_in` to the consumer. Exerts backpressure on the deserializer by withholding `ack_out` while full.

## Interface
- `DEPTH`, 8, number of byte slots; power of two, 2..16
- `WIDTH`, 8, data width in bits
- `clk_100KHz`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `data_in`  in  WIDTH  byte from deserializer; valid while `data_ready_in` = 1
- `data_ready_in`  in  1  deserializer holds high until it sees `ack_out`
- `ack_out`  out  1  one-cycle acknowledge pulse: byte captured
- `dequeue_in`  in  1  level; each cycle high with queue non-empty pops one byte
- `data_out`  out  WIDTH  last popped byte (registered), holds until next pop
- `len_out`  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- `empty_out`  out  1  `len_out` == 0
- `full_out`  out  1  `len_out` == DEPTH

## Operation
- Storage: DEPTH×WIDTH array, write pointer `wr`, read pointer `rd`, both $clog2(DEPTH) bits, wrap modulo DEPTH naturally; occupancy counter `len` separate.
- Handshake FSM, three states:
  - IDLE: `ack_out`=0. If `data_ready_in`=1 and capture allowed: write `data_in` at `wr`, `wr`+1, go ACK. Otherwise stay.
  - ACK: `ack_out`=1 for exactly this one cycle; next edge go WAIT_LOW unconditionally.
  - WAIT_LOW: `ack_out`=0; stay until `data_ready_in` sampled 0, then IDLE. Prevents double capture of the same byte.
- Capture allowed: `len` < DEPTH, or a pop occurs in the same cycle.
- Pop: `dequeue_in`=1 and `len` > 0 → `data_out` <= mem[`rd`], `rd`+1. Pop on empty ignored; `data_out` and pointers unchanged.
- Simultaneous capture and pop: both happen, `len` unchanged; if `len` was 0, the popped value is the old `data_out` hold (no pop, empty), capture only.
- `len` next = `len` + capture − pop; never exceeds DEPTH nor goes below 0.
- `empty_out`, `full_out` derived combinationally from registered `len`.

## Timing
- Reset values: `ack_out`=0, `data_out`=0, `len_out`=0, `empty_out`=1, `full_out`=0, FSM=IDLE, `wr`=`rd`=0; memory contents don't-care.
- Capture latency: byte written and `len_out` incremented on the first edge where `data_ready_in`=1 is sampled in IDLE; `ack_out` high during the following cycle.
- With the matching deserializer: data_ready rises edge 0, capture edge 1, ack high edge1–edge2, deserializer drops data_ready edge 3, FSM back to IDLE edge 4. Minimum 4 cycles per byte.
- Pop latency: `data_out` valid the cycle after the edge sampling `dequeue_in`.
- Full: FSM stays in IDLE, `ack_out` 0, deserializer holds its byte; capture resumes on first edge with room (or concurrent pop).
- Reset mid-handshake: FSM to IDLE, `ack_out` 0 at once; a byte still presented after reset release is captured as new.

## Configuration
- `FILA_DROP_OLDEST_EN` defined: capture is always allowed; when full without concurrent pop, new byte overwrites slot at `wr`, `rd`+1, `len` stays DEPTH (oldest byte discarded). No backpressure.
- Undefined (default): full queue blocks capture as described under Operation.

## Test plan
- Reset, then send 0xA5 via data_ready/data_in → `len_out`=1 one edge later, `ack_out` exactly one cycle high, no second capture while data_ready stays high through WAIT_LOW.
- Write 0x01..0x08, then hold data_ready with 0x09 → `full_out`=1, `ack_out` stays 0; pulse `dequeue_in` one cycle → `data_out`=0x01, 0x09 captured same edge, `len_out`=8.
- Fill 3 bytes, hold `dequeue_in` for 5 cycles → `data_out` sequence 0x01,0x02,0x03 then holds 0x03, `len_out`=0, `empty_out`=1.
- Push/pop 20 bytes interleaved → output order matches input across pointer wrap, `len_out` tracks exactly.
- Assert `reset` during ACK state → `ack_out`=0, `len_out`=0, `data_out`=0 immediately.
- With `FILA_DROP_OLDEST_EN`: write 0x01..0x09 → `len_out`=8, first pop returns 0x02, `ack_out` pulsed for all 9 bytes.
